booth_seq_mult: RTL
===================

# booth_seq_mult

Parametrised, sequential, signed two's-complement multiplier using Booth recoding. It performs one recoding step per clock behind a start/done handshake. It generalises the existing single-step combinational Booth cell to any operand width and an optional radix-4 mode. It sits in the feature-extraction datapath wherever a full-width product is needed without a combinational array multiplier.

## Interface
Parameters:
- WIDTH, 16, operand width in bits; ≥ 4; must be even when radix-4 is compiled in.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE or DONE
- multiplicand  in  WIDTH  signed M; captured on accepted start
- multiplier  in  WIDTH  signed Q; captured on accepted start
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse; product valid
- product  out  2*WIDTH  signed M×Q; holds until the next done

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 → RUN and load operands.
  - RUN: step counter reaches N-1 → DONE.
  - DONE: start=1 → RUN and load operands; otherwise → IDLE.
- N = WIDTH for radix-2, WIDTH/2 for radix-4.
- Load clears accumulator A, sets Q register = {multiplier, 1'b0} (appended Booth bit), latches M, and zeroes the step counter.
- Radix-2 step, decoded from Q[1:0]:
  - 00 or 11: no add.
  - 01: A+M.
  - 10: A−M.
  - Then arithmetic right shift of {A,Q} by 1.
- A is WIDTH+1 bits wide and M is sign-extended to WIDTH+1 bits. This keeps −2^(WIDTH−1) and its negation exact, with no wrap on A−M.
- Final product = {A[WIDTH−1:0], Q[WIDTH:1]}, written to the product register on the RUN→DONE edge.
- start while busy=1 is ignored; operand inputs are don't-care during RUN.
- Reset (any time, including mid-RUN): state=IDLE, busy=0, done=0, product=0, counter=0, internal registers=0. The aborted operation produces no done.

## Timing
- Start accepted at edge k. busy=1 from after edge k until after edge k+N.
- done=1 and product valid in the cycle following edge k+N. done lasts exactly one cycle.
- Back-to-back: start=1 during the DONE cycle is accepted at that edge. The result is one result every N+1 cycles, with busy=0 only during DONE.
- Outputs are registered; no combinational path from inputs to outputs.
- Reset values: busy=0, done=0, product=0.

## Configuration
- BOOTH_RADIX4_EN, when defined: radix-4 recoding.
  - Decode Q[2:0] to {0, ±M, ±2M}.
  - A widened to WIDTH+2 bits.
  - Arithmetic shift by 2 per step.
  - N = WIDTH/2.
  - Elaboration error if WIDTH is odd.
- BOOTH_RADIX4_EN undefined: radix-2 as above, N = WIDTH.
- Port list, handshake and result are identical in both builds; only latency differs.

## Structure
- Package booth_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - the recoding-select type (ZERO, ADD1, SUB1, ADD2, SUB2);
  - localparam function for N from WIDTH and radix.
- One sub-module: booth_step, the combinational single iteration.
  - Parametrised by WIDTH and radix.
  - Inputs A, Q, M; outputs next A and next Q.
  - Instantiated once; the top holds the FSM, counter and registers.

## Test plan
- WIDTH=16, M=3, Q=−5, start one cycle → done after N cycles, product=0xFFFFFFF1, busy low in DONE cycle.
- M=−32768, Q=−32768 → product=0x40000000. Also M=32767, Q=−32768 → product=0xC0008000. Checks no A−M overflow.
- M=0x1234, Q=0 → product=0. Also M=−1, Q=−1 → product=1.
- start pulsed during RUN with different operands → ignored; product is the first pair's result, single done pulse.
- rst asserted mid-RUN (step 5) → all outputs 0 at once, no done. A fresh start after deassert completes correctly.
- start held high continuously with a new operand pair each accepted cycle → results every N+1 cycles, each matching a reference model.
- Run both builds (BOOTH_RADIX4_EN defined and undefined), plus 2000 random signed pairs at WIDTH=8, 16 and 24.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and helpers for the sequential Booth multiplier.
// Build option: define BOOTH_RADIX4_EN for radix-4 recoding (two bits per step).
package booth_pkg;

`ifdef BOOTH_RADIX4_EN
    localparam bit RADIX4 = 1'b1;
`else
    localparam bit RADIX4 = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Partial-product selection produced by the Booth recoder
    typedef enum logic [2:0] {
        ZERO,
        ADD1,
        SUB1,
        ADD2,
        SUB2
    } sel_t;

    // Number of recoding steps needed for one product
    function automatic int unsigned num_steps(input int unsigned width, input bit radix4);
        return radix4 ? (width / 2) : width;
    endfunction

    // Recode the low multiplier bits (including the appended Booth bit)
    function automatic sel_t booth_decode(input logic [2:0] bits, input bit radix4);
        sel_t sel;
        sel = ZERO;
        if (radix4) begin
            case (bits)
                3'b001, 3'b010: sel = ADD1;
                3'b011:         sel = ADD2;
                3'b100:         sel = SUB2;
                3'b101, 3'b110: sel = SUB1;
                default:        sel = ZERO;
            endcase
        end else begin
            case (bits[1:0])
                2'b01:   sel = ADD1;
                2'b10:   sel = SUB1;
                default: sel = ZERO;
            endcase
        end
        return sel;
    endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational Booth iteration: add/subtract the selected multiple of M
// into A, then arithmetic-shift {A,Q} right by the radix step size.
module booth_step
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter bit          RADIX4 = 1'b0,
    localparam int unsigned AW    = RADIX4 ? (WIDTH + 2) : (WIDTH + 1)
) (
    input  logic [AW-1:0]    a,
    input  logic [WIDTH:0]   q,
    input  logic [WIDTH-1:0] m,
    output logic [AW-1:0]    a_next,
    output logic [WIDTH:0]   q_next
);

    localparam int unsigned SH = RADIX4 ? 2 : 1;

    sel_t                    sel;
    logic [AW-1:0]           m1;
    logic [AW-1:0]           m2;
    logic [AW-1:0]           sum;
    logic signed [AW+WIDTH:0] cat;

    // Recode, accumulate the selected multiple, then shift the pair right
    always_comb begin
        sel = booth_decode(q[2:0], RADIX4);
        m1  = {{(AW - WIDTH){m[WIDTH-1]}}, m};
        m2  = {m1[AW-2:0], 1'b0};
        case (sel)
            ADD1:    sum = a + m1;
            SUB1:    sum = a - m1;
            ADD2:    sum = a + m2;
            SUB2:    sum = a - m2;
            default: sum = a;
        endcase
        cat = $signed({sum, q}) >>> SH;
        {a_next, q_next} = cat;
    end

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential signed Booth multiplier with a start/done handshake.
// Build option: BOOTH_RADIX4_EN selects radix-4 (WIDTH/2 steps) instead of
// radix-2 (WIDTH steps); ports and results are identical in both builds.
module booth_seq_mult
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int unsigned AW = RADIX4 ? (WIDTH + 2) : (WIDTH + 1);
    localparam int unsigned N  = num_steps(WIDTH, RADIX4);
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

`ifdef BOOTH_RADIX4_EN
    if ((WIDTH % 2) != 0) begin : g_odd_width
        $error("booth_seq_mult: WIDTH must be even for radix-4 recoding");
    end
`endif

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [AW-1:0]    a_reg;
    logic [WIDTH:0]   q_reg;
    logic [WIDTH-1:0] m_reg;
    logic [AW-1:0]    a_nxt;
    logic [WIDTH:0]   q_nxt;

    booth_step #(
        .WIDTH  (WIDTH),
        .RADIX4 (RADIX4)
    ) u_step (
        .a      (a_reg),
        .q      (q_reg),
        .m      (m_reg),
        .a_next (a_nxt),
        .q_next (q_nxt)
    );

    // Control FSM plus datapath registers; all outputs are registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            cnt     <= '0;
            a_reg   <= '0;
            q_reg   <= '0;
            m_reg   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        cnt   <= '0;
                        a_reg <= '0;
                        q_reg <= {multiplier, 1'b0};
                        m_reg <= multiplicand;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_reg <= a_nxt;
                    q_reg <= q_nxt;
                    if (cnt == CW'(N - 1)) begin
                        // Capture from the step outputs so the product lands on the last step edge
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        product <= {a_nxt[WIDTH-1:0], q_nxt[WIDTH:1]};
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
